// File: rtl/fp_multiplier_param.sv
// Parametrised multi-cycle floating-point multiplier (shift-add mantissa, start/done handshake).
// Define FPMUL_ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates toward zero.
module fp_multiplier_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [EXP_W+MAN_W:0] a_i,
  input  logic [EXP_W+MAN_W:0] b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [EXP_W+MAN_W:0] product_o,
  output logic                 nan_o,
  output logic                 infinity_o,
  output logic                 overflow_o,
  output logic                 underflow_o,
  output logic                 inexact_o
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int M  = MAN_W + 1;
  localparam int PW = 2 * M;
  localparam int SW = EXP_W + 2;
  localparam logic signed [SW-1:0] BIAS     = SW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [SW-1:0] EXP_TOP  = SW'((1 << EXP_W) - 1);
  localparam logic signed [SW-1:0] EXP_ZERO = '0;
  localparam logic signed [SW-1:0] EXP_ONE  = SW'(1);
  localparam logic [M-1:0]         CNT_LAST = M'(MAN_W);

  typedef enum logic [2:0] {IDLE, UNPACK, MULT, NORM, ROUND, DONE} state_t;

  state_t                 state_q;
  logic [W-1:0]           a_q, b_q, product_q;
  logic                   sign_q, special_q, spec_nan_q, spec_inf_q;
  logic [PW-1:0]          ma_q, acc_q;
  logic [M-1:0]           mb_q, cnt_q;
  logic signed [SW-1:0]   exp_q;
  logic [2*MAN_W-1:0]     nrm_q;
  logic                   sticky_q, busy_q, done_q;
  logic                   nan_q, inf_q, ovf_q, unf_q, inx_q;

  logic [EXP_W-1:0]       ea, eb;
  logic [MAN_W-1:0]       fa, fb;
  logic                   a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic signed [SW-1:0]   exp_sum;

  assign ea = a_q[W-2:MAN_W];
  assign eb = b_q[W-2:MAN_W];
  assign fa = a_q[MAN_W-1:0];
  assign fb = b_q[MAN_W-1:0];
  // Subnormal operands (exp == 0, any fraction) are classified as zero.
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);
  assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

  logic [MAN_W-1:0]     frac_n, frac_fin;
  logic                 guard_b, round_b, sticky_b;
  logic signed [SW-1:0] exp_fin;
  logic [W-1:0]         product_d;
  logic                 nan_d, inf_d, ovf_d, unf_d, inx_d;
`ifdef FPMUL_ROUND_NEAREST_EN
  logic [MAN_W:0]       frac_sum;
`endif

  // Rounding and range check for the value held in nrm_q (hidden bit implicit); needs MAN_W >= 3.
  always_comb begin
    frac_n   = nrm_q[2*MAN_W-1:MAN_W];
    guard_b  = nrm_q[MAN_W-1];
    round_b  = nrm_q[MAN_W-2];
    sticky_b = sticky_q | (|nrm_q[MAN_W-3:0]);
    exp_fin  = exp_q;
`ifdef FPMUL_ROUND_NEAREST_EN
    frac_sum = {1'b0, frac_n} + {{MAN_W{1'b0}}, guard_b & (round_b | sticky_b | frac_n[0])};
    frac_fin = frac_sum[MAN_W-1:0];
    if (frac_sum[MAN_W]) exp_fin = exp_q + EXP_ONE;
`else
    frac_fin = frac_n;
`endif
    product_d = '0;
    nan_d = 1'b0;
    inf_d = 1'b0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = 1'b0;
    if (special_q) begin
      nan_d = spec_nan_q;
      inf_d = spec_inf_q;
      if (spec_nan_q)      product_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      else if (spec_inf_q) product_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else                 product_d = {sign_q, {(W-1){1'b0}}};
    end else if (exp_fin >= EXP_TOP) begin
      product_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      inf_d = 1'b1;
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else if (exp_fin <= EXP_ZERO) begin
      product_d = {sign_q, {(W-1){1'b0}}};
      unf_d = 1'b1;
      inx_d = 1'b1;
    end else begin
      product_d = {sign_q, exp_fin[EXP_W-1:0], frac_fin};
      inx_d = guard_b | round_b | sticky_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      product_q  <= '0;
      sign_q     <= 1'b0;
      special_q  <= 1'b0;
      spec_nan_q <= 1'b0;
      spec_inf_q <= 1'b0;
      ma_q       <= '0;
      acc_q      <= '0;
      mb_q       <= '0;
      cnt_q      <= '0;
      exp_q      <= '0;
      nrm_q      <= '0;
      sticky_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      nan_q      <= 1'b0;
      inf_q      <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      inx_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            a_q       <= a_i;
            b_q       <= b_i;
            product_q <= '0;
            nan_q     <= 1'b0;
            inf_q     <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            inx_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= UNPACK;
          end
        end
        UNPACK: begin
          sign_q     <= a_q[W-1] ^ b_q[W-1];
          special_q  <= 1'b1;
          spec_nan_q <= 1'b0;
          spec_inf_q <= 1'b0;
          state_q    <= ROUND;
          if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            spec_nan_q <= 1'b1;
          end else if (a_inf || b_inf) begin
            spec_inf_q <= 1'b1;
          end else if (!(a_zero || b_zero)) begin
            special_q <= 1'b0;
            ma_q      <= {{M{1'b0}}, 1'b1, fa};
            mb_q      <= {1'b1, fb};
            acc_q     <= '0;
            cnt_q     <= '0;
            exp_q     <= exp_sum;
            state_q   <= MULT;
          end
        end
        MULT: begin
          if (mb_q[0]) acc_q <= acc_q + ma_q;
          ma_q  <= ma_q << 1;
          mb_q  <= mb_q >> 1;
          cnt_q <= cnt_q + M'(1);
          if (cnt_q == CNT_LAST) state_q <= NORM;
        end
        NORM: begin
          // Product of two [1,2) mantissas lies in [1,4); bring it back to [1,2).
          if (acc_q[PW-1]) begin
            nrm_q    <= acc_q[PW-2:1];
            sticky_q <= acc_q[0];
            exp_q    <= exp_q + EXP_ONE;
          end else begin
            nrm_q    <= acc_q[PW-3:0];
            sticky_q <= 1'b0;
          end
          state_q <= ROUND;
        end
        ROUND: begin
          product_q <= product_d;
          nan_q     <= nan_d;
          inf_q     <= inf_d;
          ovf_q     <= ovf_d;
          unf_q     <= unf_d;
          inx_q     <= inx_d;
          done_q    <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign product_o   = product_q;
  assign nan_o       = nan_q;
  assign infinity_o  = inf_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
  assign inexact_o   = inx_q;

endmodule

// File: tb/tb_fp_multiplier_param.sv
// Self-checking bench for fp_multiplier_param (EXP_W=8, MAN_W=23) against an exact-arithmetic model.
// Honours FPMUL_ROUND_NEAREST_EN the same way as the design.
module tb_fp_multiplier_param;
  localparam int LAT_NORM = 27;
  localparam int LAT_SPEC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        busy_o, done_o, nan_o, infinity_o, overflow_o, underflow_o, inexact_o;
  logic [31:0] product_o;

  int checks = 0;
  int passed = 0;

  fp_multiplier_param #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .a_i(a_i), .b_i(b_i),
    .busy_o(busy_o), .done_o(done_o), .product_o(product_o),
    .nan_o(nan_o), .infinity_o(infinity_o), .overflow_o(overflow_o),
    .underflow_o(underflow_o), .inexact_o(inexact_o)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] flags_now();
    return {nan_o, infinity_o, overflow_o, underflow_o, inexact_o};
  endfunction

  // Exact integer product, then round by comparing the discarded remainder with one half.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] p, output logic [4:0] f, output int lat);
    int ea, eb, e, sh;
    longint unsigned ma, mb, prod, q, rem, half;
    logic sg, az, ai, an, bz, bi, bn;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = 64'(a[22:0]);
    mb = 64'(b[22:0]);
    az = (ea == 0);
    bz = (eb == 0);
    ai = (ea == 255) && (ma == 0);
    bi = (eb == 255) && (mb == 0);
    an = (ea == 255) && (ma != 0);
    bn = (eb == 255) && (mb != 0);
    sg = a[31] ^ b[31];
    f = '0;
    lat = LAT_SPEC;
    p = '0;
    if (an || bn || (ai && bz) || (bi && az)) begin
      p = 32'h7FC00000;
      f = 5'b10000;
    end else if (ai || bi) begin
      p = {sg, 8'hFF, 23'h0};
      f = 5'b01000;
    end else if (az || bz) begin
      p = {sg, 31'h0};
    end else begin
      lat = LAT_NORM;
      prod = (ma + 64'h80_0000) * (mb + 64'h80_0000);
      e = ea + eb - 127;
      sh = 23;
      if (prod >= 64'h8000_0000_0000) begin
        sh = 24;
        e = e + 1;
      end
      q = prod >> sh;
      rem = prod - (q << sh);
      half = 64'd1 << (sh - 1);
`ifdef FPMUL_ROUND_NEAREST_EN
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == 64'h100_0000) begin
        q = q >> 1;
        e = e + 1;
      end
`else
      if (half == 0) q = 0;
`endif
      if (e >= 255) begin
        p = {sg, 8'hFF, 23'h0};
        f = 5'b01101;
      end else if (e <= 0) begin
        p = {sg, 31'h0};
        f = 5'b00011;
      end else begin
        p = {sg, e[7:0], q[22:0]};
        f = {4'b0000, rem != 0};
      end
    end
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 9);
    if (k < 6) v[30:23] = 8'($urandom_range(100, 154));
    else if (k < 9) v[30:23] = 8'($urandom_range(1, 254));
    else begin
      v[30:23] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
      if ($urandom_range(0, 1) == 1) v[22:0] = '0;
    end
    return v;
  endfunction

  // Drives one operation; optionally pulses start with junk operands lat cycles after accept.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int interfere,
                        output logic [31:0] p, output logic [4:0] f, output int lat,
                        output bit busy_ok);
    bit seen;
    @(negedge clk);
    a_i = a;
    b_i = b;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    lat = 0;
    seen = 1'b0;
    busy_ok = 1'b1;
    while (!seen && lat < 200) begin
      if (lat == interfere) begin
        start_i = 1'b1;
        a_i = $urandom;
        b_i = $urandom;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (!busy_o) busy_ok = 1'b0;
      if (done_o) seen = 1'b1;
    end
    start_i = 1'b0;
    p = product_o;
    f = flags_now();
    checks++;
    if (!seen) $display("FAIL done_timeout a=%h b=%h: no done_o within %0d cycles, required one", a, b, lat);
    else passed++;
    $display("op %h x %h -> %h flags(n,i,o,u,x)=%b latency=%0d", a, b, p, f, lat);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({busy_o, done_o, product_o, flags_now()} !== 39'd0)
      $display("FAIL reset_outputs: got busy=%b done=%b prod=%h flags=%b, required all 0",
               busy_o, done_o, product_o, flags_now());
    else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] ta [10], tb [10], tp [10];
    logic [4:0]  tf [10];
    int          tl [10];
    logic [31:0] p;
    logic [4:0]  f;
    int lat;
    bit bok;
    ta[0] = 32'h40400000; tb[0] = 32'h40000000; tp[0] = 32'h40C00000; tf[0] = 5'b00000; tl[0] = 27;
    ta[1] = 32'h3F800001; tb[1] = 32'h3FC00000; tf[1] = 5'b00001; tl[1] = 27;
`ifdef FPMUL_ROUND_NEAREST_EN
    tp[1] = 32'h3FC00002;
`else
    tp[1] = 32'h3FC00001;
`endif
    ta[2] = 32'h7F000000; tb[2] = 32'h7F000000; tp[2] = 32'h7F800000; tf[2] = 5'b01101; tl[2] = 27;
    ta[3] = 32'h00800000; tb[3] = 32'h00800000; tp[3] = 32'h00000000; tf[3] = 5'b00011; tl[3] = 27;
    ta[4] = 32'h7F800000; tb[4] = 32'h00000000; tp[4] = 32'h7FC00000; tf[4] = 5'b10000; tl[4] = 2;
    ta[5] = 32'hFF800000; tb[5] = 32'h40000000; tp[5] = 32'hFF800000; tf[5] = 5'b01000; tl[5] = 2;
    ta[6] = 32'h80000000; tb[6] = 32'h3F800000; tp[6] = 32'h80000000; tf[6] = 5'b00000; tl[6] = 2;
    ta[7] = 32'h7F800001; tb[7] = 32'h3F800000; tp[7] = 32'h7FC00000; tf[7] = 5'b10000; tl[7] = 2;
    ta[8] = 32'h00000001; tb[8] = 32'h40000000; tp[8] = 32'h00000000; tf[8] = 5'b00000; tl[8] = 2;
    ta[9] = 32'hC0000000; tb[9] = 32'h3F000000; tp[9] = 32'hBF800000; tf[9] = 5'b00000; tl[9] = 27;
    for (int i = 0; i < 10; i++) begin
      run_op(ta[i], tb[i], -1, p, f, lat, bok);
      checks++;
      if (p !== tp[i]) $display("FAIL dir%0d_product: got %h, required %h", i, p, tp[i]);
      else passed++;
      checks++;
      if (f !== tf[i]) $display("FAIL dir%0d_flags: got %b, required %b", i, f, tf[i]);
      else passed++;
      checks++;
      if (lat != tl[i]) $display("FAIL dir%0d_latency: got %0d, required %0d", i, lat, tl[i]);
      else passed++;
      checks++;
      if (!bok) $display("FAIL dir%0d_busy: busy_o dropped before done (got 0, required 1)", i);
      else passed++;
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] p;
    logic [4:0] f;
    int lat;
    bit bok;
    run_op(32'h40400000, 32'h40000000, 5, p, f, lat, bok);
    checks++;
    if (p !== 32'h40C00000) $display("FAIL ignore_start_product: got %h, required 40c00000", p);
    else passed++;
    checks++;
    if (lat != LAT_NORM) $display("FAIL ignore_start_latency: got %0d, required %0d", lat, LAT_NORM);
    else passed++;
  endtask

  task automatic test_abort();
    logic [31:0] p;
    logic [4:0] f;
    int lat;
    bit bok;
    @(negedge clk);
    a_i = 32'h40400000;
    b_i = 32'h40000000;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy_o, done_o, product_o, flags_now()} !== 39'd0)
      $display("FAIL abort_async: got busy=%b done=%b prod=%h, required all 0", busy_o, done_o, product_o);
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if ({busy_o, done_o, product_o, flags_now()} !== 39'd0)
      $display("FAIL abort_next_cycle: got busy=%b done=%b prod=%h, required all 0", busy_o, done_o, product_o);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    run_op(32'h3F800000, 32'h40A00000, -1, p, f, lat, bok);
    checks++;
    if (p !== 32'h40A00000 || f !== 5'b00000)
      $display("FAIL abort_recover: got %h/%b, required 40a00000/00000", p, f);
    else passed++;
    checks++;
    if (lat != LAT_NORM) $display("FAIL abort_recover_latency: got %0d, required %0d", lat, LAT_NORM);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] oa [3], ob [3], ep [3];
    logic [4:0] ef;
    int el, idx, gap, cyc;
    oa[0] = 32'h40400000; ob[0] = 32'h40000000;
    oa[1] = 32'h7F800000; ob[1] = 32'h3F800000;
    oa[2] = 32'h3FC00000; ob[2] = 32'hC0400000;
    for (int i = 0; i < 3; i++) model(oa[i], ob[i], ep[i], ef, el);
    @(negedge clk);
    a_i = oa[0];
    b_i = ob[0];
    start_i = 1'b1;
    @(posedge clk);
    #1;
    idx = 0;
    gap = 0;
    cyc = 0;
    while (idx < 3 && cyc < 300) begin
      if (busy_o) begin
        if (gap != 0) begin
          checks++;
          if (gap != 1) $display("FAIL b2b_idle_gap: got %0d idle cycles, required 1", gap);
          else passed++;
          gap = 0;
        end
        a_i = $urandom;
        b_i = $urandom;
      end else begin
        gap++;
        a_i = oa[idx];
        b_i = ob[idx];
      end
      if (done_o) begin
        checks++;
        if (product_o !== ep[idx]) $display("FAIL b2b_product%0d: got %h, required %h", idx, product_o, ep[idx]);
        else passed++;
        idx++;
        if (idx == 3) start_i = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start_i = 1'b0;
    checks++;
    if (idx != 3) $display("FAIL b2b_timeout: got %0d results, required 3", idx);
    else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [31:0] a, b, p, ep;
    logic [4:0] f, ef;
    int lat, el;
    bit bok;
    for (int i = 0; i < 40; i++) begin
      a = rand_operand();
      b = rand_operand();
      model(a, b, ep, ef, el);
      run_op(a, b, -1, p, f, lat, bok);
      checks++;
      if (p !== ep) $display("FAIL rand%0d_product %h x %h: got %h, required %h", i, a, b, p, ep);
      else passed++;
      checks++;
      if (f !== ef) $display("FAIL rand%0d_flags %h x %h: got %b, required %b", i, a, b, f, ef);
      else passed++;
      checks++;
      if (lat != el || !bok) $display("FAIL rand%0d_timing: got latency %0d busy_ok %0d, required %0d/1", i, lat, bok, el);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
